// File: rtl/clock_freq_meter_pkg.sv
// Shared types and defaults for the clock measurement tools.
// State encoding and synchronizer depth used by the meter and its helpers.
package clock_freq_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2
   } meter_state_e;

   localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/clock_freq_meter_sync_edge_detect.sv
// Synchronizes an asynchronous signal and flags its rising edges.
// Latency from input rise to rise_o is SYNC_STAGES+1 clocks.
module sync_edge_detect
   import clock_freq_meter_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sig_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/clock_freq_meter.sv
// Gated edge counter and edge-to-edge period meter for a slow
// or external clock observed in the clk_in domain.
module clock_freq_meter
   import clock_freq_meter_pkg::*;
#(
   parameter int unsigned GATE_CYCLES  = 1000,
   parameter int unsigned COUNT_WIDTH  = 16,
   parameter int unsigned PERIOD_WIDTH = 16,
   parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES
) (
   input  logic                    clk_in,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    sig_in,
   output logic [COUNT_WIDTH-1:0]  edge_count,
   output logic                    count_valid,
   output logic                    overflow,
   output logic                    sig_present,
   output logic [PERIOD_WIDTH-1:0] period,
   output logic                    period_valid
);

   localparam int unsigned GW = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

   meter_state_e state_q, state_d;

   logic [GW-1:0]           gate_cnt_q, gate_cnt_d;
   logic [COUNT_WIDTH-1:0]  edge_cnt_q, edge_cnt_d;
   logic                    win_ovf_q, win_ovf_d;
   logic [PERIOD_WIDTH-1:0] per_cnt_q, per_cnt_d;
   logic                    armed_q, armed_d;

   logic [COUNT_WIDTH-1:0]  edge_count_q, edge_count_d;
   logic                    overflow_q, overflow_d;
   logic                    present_q, present_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic                    cv_q, cv_d;
   logic                    pv_q, pv_d;

   logic                    rise;
   logic                    measuring;
   logic                    win_end;
   logic                    edge_sat;
   logic [COUNT_WIDTH-1:0]  edge_sum;
   logic                    ovf_sum;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i  (clk_in),
      .rst_ni (reset_n),
      .sig_i  (sig_in),
      .rise_o (rise)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (enable) state_d = ST_ARM;
         ST_ARM:     state_d = ST_MEASURE;
         ST_MEASURE: state_d = ST_MEASURE;
         default:    state_d = ST_IDLE;
      endcase
      if (!enable) state_d = ST_IDLE;
   end

   // A rise on the last gate cycle still belongs to the closing window.
   assign measuring = (state_q == ST_MEASURE) && enable;
   assign win_end   = measuring && (gate_cnt_q == GATE_LAST);
   assign edge_sat  = &edge_cnt_q;
   assign edge_sum  = edge_sat ? edge_cnt_q
                               : edge_cnt_q + COUNT_WIDTH'(rise);
   assign ovf_sum   = win_ovf_q | (edge_sat & rise);

   always_comb begin
      gate_cnt_d   = '0;
      edge_cnt_d   = '0;
      win_ovf_d    = 1'b0;
      per_cnt_d    = '0;
      armed_d      = 1'b0;
      edge_count_d = edge_count_q;
      overflow_d   = overflow_q;
      present_d    = present_q;
      period_d     = period_q;
      cv_d         = 1'b0;
      pv_d         = 1'b0;
      if (measuring) begin
         if (win_end) begin
            edge_count_d = edge_sum;
            overflow_d   = ovf_sum;
            present_d    = |edge_sum;
            cv_d         = 1'b1;
         end else begin
            gate_cnt_d = gate_cnt_q + GW'(1);
            edge_cnt_d = edge_sum;
            win_ovf_d  = ovf_sum;
         end
         armed_d = armed_q | rise;
         if (rise) begin
            per_cnt_d = PERIOD_WIDTH'(1);
            if (armed_q) begin
               period_d = per_cnt_q;
               pv_d     = 1'b1;
            end
         end else if (armed_q) begin
            per_cnt_d = (&per_cnt_q) ? per_cnt_q
                                     : per_cnt_q + PERIOD_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         gate_cnt_q   <= '0;
         edge_cnt_q   <= '0;
         win_ovf_q    <= 1'b0;
         per_cnt_q    <= '0;
         armed_q      <= 1'b0;
         edge_count_q <= '0;
         overflow_q   <= 1'b0;
         present_q    <= 1'b0;
         period_q     <= '0;
         cv_q         <= 1'b0;
         pv_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         gate_cnt_q   <= gate_cnt_d;
         edge_cnt_q   <= edge_cnt_d;
         win_ovf_q    <= win_ovf_d;
         per_cnt_q    <= per_cnt_d;
         armed_q      <= armed_d;
         edge_count_q <= edge_count_d;
         overflow_q   <= overflow_d;
         present_q    <= present_d;
         period_q     <= period_d;
         cv_q         <= cv_d;
         pv_q         <= pv_d;
      end
   end

   assign edge_count   = edge_count_q;
   assign count_valid  = cv_q;
   assign overflow     = overflow_q;
   assign sig_present  = present_q;
   assign period       = period_q;
   assign period_valid = pv_q;

endmodule

// File: tb/tb_clock_freq_meter.sv
// Bench for clock_freq_meter: two instances (wide and narrow counters)
// checked every cycle against an event-time reference model.
module tb_clock_freq_meter;

   localparam int G = 100;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic reset_n = 1'b0;
   logic enable  = 1'b0;
   logic sig_in  = 1'b0;

   logic [15:0] a_edge_count;
   logic        a_count_valid, a_overflow, a_sig_present;
   logic [15:0] a_period;
   logic        a_period_valid;
   logic [2:0]  b_edge_count;
   logic        b_count_valid, b_overflow, b_sig_present;
   logic [3:0]  b_period;
   logic        b_period_valid;

   clock_freq_meter #(
      .GATE_CYCLES(G), .COUNT_WIDTH(16),
      .PERIOD_WIDTH(16), .SYNC_STAGES(2)
   ) u_a (
      .clk_in(clk_in), .reset_n(reset_n),
      .enable(enable), .sig_in(sig_in),
      .edge_count(a_edge_count),
      .count_valid(a_count_valid),
      .overflow(a_overflow),
      .sig_present(a_sig_present),
      .period(a_period),
      .period_valid(a_period_valid)
   );

   clock_freq_meter #(
      .GATE_CYCLES(G), .COUNT_WIDTH(3),
      .PERIOD_WIDTH(4), .SYNC_STAGES(2)
   ) u_b (
      .clk_in(clk_in), .reset_n(reset_n),
      .enable(enable), .sig_in(sig_in),
      .edge_count(b_edge_count),
      .count_valid(b_count_valid),
      .overflow(b_overflow),
      .sig_present(b_sig_present),
      .period(b_period),
      .period_valid(b_period_valid)
   );

   int npass = 0;
   int nfail = 0;
   int ntot  = 0;

   // reference model state
   int cyc      = 0;
   bit s_h[0:8191];
   int last_rst = 0;
   int en_start = -1;
   int ecnt     = 0;
   int last_ev  = -1;
   int raw_cnt  = 0;
   int raw_per  = 0;
   bit exp_cv   = 1'b0;
   bit exp_pv   = 1'b0;

   // stimulus state
   bit rst_v    = 1'b0;
   bit prev_rst = 1'b0;
   bit en_v     = 1'b0;
   int mode     = 0;
   int per      = 4;
   int ph       = 0;
   int hold     = 0;
   int phase    = 0;
   int npv5     = 0;

   function automatic int sat(int raw, int w);
      int m;
      m = (1 << w) - 1;
      return (raw > m) ? m : raw;
   endfunction

   function automatic bit sv(int j);
      if (j < 0 || j <= last_rst) return 1'b0;
      return s_h[j];
   endfunction

   task automatic chk(string tag, int obs, int exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      last_rst = cyc;
      en_start = -1;
      ecnt     = 0;
      last_ev  = -1;
      raw_cnt  = 0;
      raw_per  = 0;
      exp_cv   = 1'b0;
      exp_pv   = 1'b0;
   endtask

   // A sampled 0->1 of sig_in at edge j is seen by the counters at j+3.
   task automatic model_edge();
      bit ev;
      int k;
      cyc++;
      s_h[cyc] = sig_in;
      exp_cv = 1'b0;
      exp_pv = 1'b0;
      if (!reset_n) begin
         model_reset();
         return;
      end
      ev = sv(cyc - 3) && !sv(cyc - 4);
      if (!enable) begin
         en_start = -1;
         ecnt     = 0;
         last_ev  = -1;
      end else if (en_start < 0) begin
         en_start = cyc;
      end else if (cyc >= en_start + 2) begin
         k = cyc - en_start - 2;
         if (ev) ecnt++;
         if ((k % G) == G - 1) begin
            raw_cnt = ecnt;
            ecnt    = 0;
            exp_cv  = 1'b1;
         end
         if (ev) begin
            if (last_ev >= 0) begin
               raw_per = cyc - last_ev;
               exp_pv  = 1'b1;
            end
            last_ev = cyc;
         end
      end else begin
         ecnt    = 0;
         last_ev = -1;
      end
   endtask

   task automatic check_all();
      chk("a_edge_count", int'(a_edge_count), sat(raw_cnt, 16));
      chk("a_overflow", int'(a_overflow), raw_cnt > 65535 ? 1 : 0);
      chk("a_sig_present", int'(a_sig_present), raw_cnt > 0 ? 1 : 0);
      chk("a_count_valid", int'(a_count_valid), exp_cv ? 1 : 0);
      chk("a_period", int'(a_period), sat(raw_per, 16));
      chk("a_period_valid", int'(a_period_valid), exp_pv ? 1 : 0);
      chk("b_edge_count", int'(b_edge_count), sat(raw_cnt, 3));
      chk("b_overflow", int'(b_overflow), raw_cnt > 7 ? 1 : 0);
      chk("b_sig_present", int'(b_sig_present), raw_cnt > 0 ? 1 : 0);
      chk("b_count_valid", int'(b_count_valid), exp_cv ? 1 : 0);
      chk("b_period", int'(b_period), sat(raw_per, 4));
      chk("b_period_valid", int'(b_period_valid), exp_pv ? 1 : 0);
   endtask

   task automatic step();
      @(negedge clk_in);
      reset_n = rst_v;
      enable  = en_v;
      case (mode)
         0: sig_in = 1'b0;
         1: begin
            sig_in = ((ph % per) < (per / 2)) ? 1'b1 : 1'b0;
            ph++;
         end
         2: begin
            if (hold == 0) begin
               sig_in = ~sig_in;
               hold   = int'($urandom_range(1, 12));
            end
            hold--;
         end
         default: sig_in = 1'($urandom_range(0, 1));
      endcase
      if (prev_rst && !rst_v) begin
         model_reset();
         #1;
         check_all();
      end
      prev_rst = rst_v;
      @(posedge clk_in);
      model_edge();
      #1;
      check_all();
      if (phase == 2) begin
         if (exp_cv) begin
            chk("sq4_a_count", int'(a_edge_count), 25);
            chk("sq4_b_count", int'(b_edge_count), 7);
            chk("sq4_b_ovf", int'(b_overflow), 1);
         end
         if (exp_pv) chk("sq4_a_period", int'(a_period), 4);
      end
      if (phase == 5 && exp_pv) begin
         npv5++;
         if (npv5 >= 3) begin
            chk("sq40_a_period", int'(a_period), 40);
            chk("sq40_b_period_sat", int'(b_period), 15);
         end
      end
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst_v = 1'b0; en_v = 1'b0; mode = 3;
      run(10);
      rst_v = 1'b1;
      run(20);
      mode = 1; per = 4; ph = 0;
      run(20);
      phase = 2; en_v = 1'b1;
      run(350);
      phase = 0; mode = 0;
      run(250);
      mode = 2; hold = 0;
      run(400);
      mode = 3;
      run(200);
      mode = 1; per = 40; ph = 0; phase = 5; npv5 = 0;
      run(300);
      phase = 0; per = 4; ph = 0;
      run(150);
      en_v = 1'b0;
      run(10);
      en_v = 1'b1;
      run(220);
      mode = 2;
      run(150);
      rst_v = 1'b0;
      run(5);
      rst_v = 1'b1;
      run(250);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
